// File: rtl/knn_pkg.sv
// Shared types and sizes for the kNN frame loader and its vector bank.
package knn_pkg;

    localparam int unsigned VEC_W      = 64;
    localparam int unsigned NUM_SEARCH = 8;
    localparam int unsigned DIM        = 16;
    localparam int unsigned ELEM_W     = 4;
    localparam int unsigned NUM_SLOTS  = NUM_SEARCH + 1;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [2:0]       beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DROP
    } loader_state_t;

    // Slot 0 is the query, slots 1..NUM_SEARCH are search_0..search_7.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input int unsigned slot);
        return NUM_SLOTS'(1) << slot;
    endfunction

endpackage

// File: rtl/knn_vec_bank.sv
// Double-buffered vector bank: per-slot shadow writes, bulk copy to the output
// registers on a commit strobe.
module knn_vec_bank
    import knn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] wr_en,
    input  logic [VEC_W-1:0]     wr_data,
    input  logic                 commit,
    input  logic                 keep_query,
    output vec_t                 out_vec [NUM_SLOTS]
);

    vec_t shadow [NUM_SLOTS];
    vec_t out_q  [NUM_SLOTS];

    // A commit on the same edge as a shadow write copies the old shadow value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                shadow[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                if (wr_en[k]) begin
                    shadow[k] <= wr_data;
                end
                if (commit && !(k == 0 && keep_query)) begin
                    out_q[k] <= shadow[k];
                end
            end
        end
    end

    assign out_vec = out_q;

endmodule

// File: rtl/knn_frame_loader.sv
// Frame assembler feeding dist_sort: 1 query + 8 search beats, framing checked on s_last.
// Optional KNN_LOADER_QUERY_REUSE_EN adds s_reuse_q for 8-beat frames reusing the last query.
module knn_frame_loader
    import knn_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [VEC_W-1:0] s_data,
    input  logic             s_last,
`ifdef KNN_LOADER_QUERY_REUSE_EN
    input  logic             s_reuse_q,
`endif
    output logic [VEC_W-1:0] query,
    output logic [VEC_W-1:0] search_0,
    output logic [VEC_W-1:0] search_1,
    output logic [VEC_W-1:0] search_2,
    output logic [VEC_W-1:0] search_3,
    output logic [VEC_W-1:0] search_4,
    output logic [VEC_W-1:0] search_5,
    output logic [VEC_W-1:0] search_6,
    output logic [VEC_W-1:0] search_7,
    output logic             dist_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam beat_idx_t LastIdx = beat_idx_t'(NUM_SEARCH - 1);

    loader_state_t        state;
    beat_idx_t            idx;
    logic                 ready_q;
    logic                 accept;
    logic                 reuse_req;
    logic                 frame_reuse;
    logic                 commit_pend;
    logic                 commit_keep;
    logic [NUM_SLOTS-1:0] wr_en;
    vec_t                 bank_out [NUM_SLOTS];

    assign s_ready = ready_q;
    assign accept  = s_valid & ready_q;

`ifdef KNN_LOADER_QUERY_REUSE_EN
    assign reuse_req = s_reuse_q;
`else
    assign reuse_req = 1'b0;
`endif

    // A reuse frame's first beat lands directly in search_0.
    always_comb begin
        wr_en = '0;
        if (accept) begin
            unique case (state)
                IDLE:    wr_en = slot_onehot(reuse_req ? 1 : 0);
                LOAD:    wr_en = slot_onehot(int'(idx) + 1);
                default: wr_en = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            ready_q     <= 1'b0;
            frame_reuse <= 1'b0;
            commit_pend <= 1'b0;
            commit_keep <= 1'b0;
            dist_valid  <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            ready_q     <= 1'b1;
            dist_valid  <= commit_pend;
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
            if (commit_pend && frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (s_last) begin
                            frame_err <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            idx         <= reuse_req ? beat_idx_t'(1) : '0;
                            frame_reuse <= reuse_req;
                        end
                    end
                    LOAD: begin
                        if (idx == LastIdx) begin
                            state <= s_last ? IDLE : DROP;
                            if (s_last) begin
                                commit_pend <= 1'b1;
                                commit_keep <= frame_reuse;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    DROP: begin
                        if (s_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    knn_vec_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (s_data),
        .commit    (commit_pend),
        .keep_query(commit_keep),
        .out_vec   (bank_out)
    );

    assign query    = bank_out[0];
    assign search_0 = bank_out[1];
    assign search_1 = bank_out[2];
    assign search_2 = bank_out[3];
    assign search_3 = bank_out[4];
    assign search_4 = bank_out[5];
    assign search_5 = bank_out[6];
    assign search_6 = bank_out[7];
    assign search_7 = bank_out[8];

endmodule

// File: tb/tb_knn_frame_loader.sv
// Self-checking bench for knn_frame_loader against a frame-level reference model.
module tb_knn_frame_loader;
    import knn_pkg::*;

    localparam int FW = 9 * 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic s_reuse_q = 1'b0;
    vec_t s_data = '0;
    logic s_ready;
    vec_t query, search_0, search_1, search_2, search_3;
    vec_t search_4, search_5, search_6, search_7;
    logic dist_valid, frame_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    knn_frame_loader #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
`ifdef KNN_LOADER_QUERY_REUSE_EN
        .s_reuse_q (s_reuse_q),
`endif
        .query     (query),
        .search_0  (search_0),
        .search_1  (search_1),
        .search_2  (search_2),
        .search_3  (search_3),
        .search_4  (search_4),
        .search_5  (search_5),
        .search_6  (search_6),
        .search_7  (search_7),
        .dist_valid(dist_valid),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    wire [FW-1:0] dut_flat = {search_7, search_6, search_5, search_4,
                              search_3, search_2, search_1, search_0, query};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: expected event times and committed frame contents.
    int            exp_dv_cyc[$];
    logic [FW-1:0] exp_dv_dat[$];
    int            exp_fe_cyc[$];
    logic [FW-1:0] exp_out = '0;
    logic [15:0]   exp_cnt = '0;
    vec_t          seg[$];
    bit            seg_reuse = 1'b0;
    bit            dropping = 1'b0;
    vec_t          m_query = '0;
    int            dv_log[$];
    int            fe_log[$];
    int            acc_log[$];

    function automatic vec_t rand_vec();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_dv_cyc.delete();
        exp_dv_dat.delete();
        exp_fe_cyc.delete();
        seg.delete();
        exp_out   = '0;
        exp_cnt   = '0;
        seg_reuse = 1'b0;
        dropping  = 1'b0;
        m_query   = '0;
    endtask

    // A segment is every beat up to s_last; it is good only if it has exactly the
    // required length. Overlong segments fault at the required length, rest dropped.
    task automatic model_beat(input int acc, input vec_t d, input bit last, input bit reuse);
        logic [FW-1:0] f;
        int need;
        if (dropping) begin
            if (last) dropping = 1'b0;
            return;
        end
        if (seg.size() == 0) seg_reuse = reuse;
        seg.push_back(d);
        need = seg_reuse ? 8 : 9;
        if (seg.size() == need) begin
            if (last) begin
                f = '0;
                f[63:0] = seg_reuse ? m_query : seg[0];
                for (int s = 0; s < 8; s++) f[(s+1)*64 +: 64] = seg[seg_reuse ? s : s + 1];
                m_query = f[63:0];
                exp_dv_cyc.push_back(acc + 1);
                exp_dv_dat.push_back(f);
            end else begin
                exp_fe_cyc.push_back(acc);
                dropping = 1'b1;
            end
            seg.delete();
        end else if (last) begin
            exp_fe_cyc.push_back(acc);
            seg.delete();
        end
    endtask

    // Cycle-by-cycle scoreboard: pulses, held outputs and counter.
    always @(negedge clk) begin : mon
        bit want_dv;
        bit want_fe;
        if (mon_en) begin
            while (exp_dv_cyc.size() > 0 && exp_dv_cyc[0] < cyc) begin
                void'(exp_dv_cyc.pop_front());
                void'(exp_dv_dat.pop_front());
            end
            while (exp_fe_cyc.size() > 0 && exp_fe_cyc[0] < cyc) void'(exp_fe_cyc.pop_front());
            want_dv = exp_dv_cyc.size() > 0 && exp_dv_cyc[0] == cyc;
            want_fe = exp_fe_cyc.size() > 0 && exp_fe_cyc[0] == cyc;
            if (want_dv) begin
                void'(exp_dv_cyc.pop_front());
                exp_out = exp_dv_dat.pop_front();
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            if (want_fe) void'(exp_fe_cyc.pop_front());
            if (dist_valid) dv_log.push_back(cyc);
            if (frame_err) fe_log.push_back(cyc);
            checks += 4;
            if (dist_valid !== want_dv) begin
                errors++;
                $display("FAIL dist_valid cyc=%0d got %b expected %b", cyc, dist_valid, want_dv);
            end
            if (frame_err !== want_fe) begin
                errors++;
                $display("FAIL frame_err cyc=%0d got %b expected %b", cyc, frame_err, want_fe);
            end
            if (dut_flat !== exp_out) begin
                errors++;
                $display("FAIL vectors cyc=%0d got %h expected %h", cyc, dut_flat, exp_out);
            end
            if (frame_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL frame_cnt cyc=%0d got %0d expected %0d", cyc, frame_cnt, exp_cnt);
            end
        end
    end

    // Called at a negedge; returns at the following negedge after the beat is accepted.
    task automatic drive(input vec_t d, input bit last, input bit reuse);
        int n = 0;
        int acc;
        bit r;
`ifdef KNN_LOADER_QUERY_REUSE_EN
        r = reuse;
`else
        r = 1'b0;
`endif
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        s_reuse_q = r;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout got %b expected 1", s_ready);
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        acc_log.push_back(acc);
        model_beat(acc, d, last, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last = 1'b0;
        s_reuse_q = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beats(input int n, input int last_pos, input bit reuse_first);
        for (int i = 1; i <= n; i++) drive(rand_vec(), i == last_pos, i == 1 && reuse_first);
    endtask

    task automatic clear_logs();
        dv_log.delete();
        fe_log.delete();
        acc_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = rand_vec();
        repeat (3) @(negedge clk);
        checks += 4;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready got %b expected 0", s_ready);
        end
        if (dist_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b%b expected 00", dist_valid, frame_err);
        end
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d expected 0", frame_cnt);
        end
        if (dut_flat !== '0) begin
            errors++;
            $display("FAIL reset_vectors got %h expected 0", dut_flat);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_s_ready got %b expected 1", s_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] nib;
        clear_logs();
        drive(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            nib = k[3:0];
            drive({16{nib}}, k == 7, 1'b0);
        end
        idle(3);
        checks += 5;
        if (search_3 !== 64'h3333_3333_3333_3333) begin
            errors++;
            $display("FAIL basic_search_3 got %h expected 3333333333333333", search_3);
        end
        if (query !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL basic_query got %h expected 0123456789abcdef", query);
        end
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_frame_cnt got %0d expected 1", frame_cnt);
        end
        if (dv_log.size() != 1 || dv_log[0] != acc_log[8] + 1) begin
            errors++;
            $display("FAIL basic_latency got %0d pulses expected 1 at cyc %0d",
                     dv_log.size(), acc_log[8] + 1);
        end
        if (fe_log.size() != 0) begin
            errors++;
            $display("FAIL basic_frame_err got %0d pulses expected 0", fe_log.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_beats(9, 9, 1'b0);
        drive(64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0);
        send_beats(8, 8, 1'b0);
        idle(3);
        checks += 2;
        if (dv_log.size() != 2 || dv_log[1] - dv_log[0] != 9) begin
            errors++;
            $display("FAIL b2b_spacing got %0d pulses expected 2 pulses 9 apart", dv_log.size());
        end
        if (query !== 64'hFFFF_0000_FFFF_0000) begin
            errors++;
            $display("FAIL b2b_query got %h expected ffff0000ffff0000", query);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] cnt0;
        logic [FW-1:0] held;
        clear_logs();
        cnt0 = frame_cnt;
        held = dut_flat;
        send_beats(5, 5, 1'b0);
        idle(3);
        checks += 3;
        if (fe_log.size() != 1 || dv_log.size() != 0) begin
            errors++;
            $display("FAIL short_pulses got err=%0d dv=%0d expected err=1 dv=0",
                     fe_log.size(), dv_log.size());
        end
        if (dut_flat !== held) begin
            errors++;
            $display("FAIL short_hold got %h expected %h", dut_flat, held);
        end
        send_beats(9, 9, 1'b0);
        idle(3);
        if (frame_cnt !== cnt0 + 16'd1) begin
            errors++;
            $display("FAIL short_recover_cnt got %0d expected %0d", frame_cnt, cnt0 + 16'd1);
        end
    endtask

    task automatic test_long_frame();
        clear_logs();
        send_beats(12, 12, 1'b0);
        idle(3);
        checks += 2;
        if (fe_log.size() != 1 || fe_log[0] != acc_log[8] || dv_log.size() != 0) begin
            errors++;
            $display("FAIL long_err got err=%0d dv=%0d expected one err at cyc %0d",
                     fe_log.size(), dv_log.size(), acc_log[8]);
        end
        clear_logs();
        send_beats(9, 9, 1'b0);
        idle(3);
        if (dv_log.size() != 1) begin
            errors++;
            $display("FAIL long_recover got %0d pulses expected 1", dv_log.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send_beats(4, 0, 1'b0);
        idle(0);
        mon_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (dut_flat !== '0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_zero got cnt=%0d vec=%h expected 0", frame_cnt, dut_flat);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        mon_en = 1'b1;
        send_beats(9, 9, 1'b0);
        idle(3);
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_cnt got %0d expected 1", frame_cnt);
        end
    endtask

`ifdef KNN_LOADER_QUERY_REUSE_EN
    task automatic test_reuse();
        vec_t q;
        vec_t first;
        clear_logs();
        q = rand_vec();
        first = rand_vec();
        drive(q, 1'b0, 1'b0);
        send_beats(8, 8, 1'b0);
        drive(first, 1'b0, 1'b1);
        send_beats(7, 7, 1'b0);
        idle(3);
        checks += 2;
        if (query !== q || dv_log.size() != 2) begin
            errors++;
            $display("FAIL reuse_query got %h expected %h", query, q);
        end
        if (search_0 !== first) begin
            errors++;
            $display("FAIL reuse_search_0 got %h expected %h", search_0, first);
        end
    endtask
`endif

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(0, 9);
            int len = 9;
            bit ru = 1'b0;
`ifdef KNN_LOADER_QUERY_REUSE_EN
            if (kind >= 6 && kind < 8) begin
                ru = 1'b1;
                len = 8;
            end
`endif
            if (kind >= 8) len = $urandom_range(1, 12);
            for (int i = 1; i <= len; i++) begin
                drive(rand_vec(), i == len, i == 1 && ru);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(4);
        checks++;
        if (exp_dv_cyc.size() != 0 || exp_fe_cyc.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d/%0d pending expected 0/0",
                     exp_dv_cyc.size(), exp_fe_cyc.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
`ifdef KNN_LOADER_QUERY_REUSE_EN
        test_reuse();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
